// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: control stage in front of the 8-bit ALU.
// Accepts one operation per req handshake, drives the ALU operands/mode and
// the ee/eo strobes through LOAD -> EXEC* -> READ, captures the bus result
// with its flags, and presents it on the rsp handshake.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   req_valid/req_ready              request handshake (req_ready is combinational)
//   req_mode, req_a, req_b           operation payload
//   alu_in_a, alu_in_b, alu_mode     registered operands/mode to the ALU
//   alu_ee, alu_eo                   ALU execute / bus output enables
//   alu_bus, alu_carry               ALU result bus and carry flag
//   rsp_valid/rsp_ready              response handshake
//   rsp_data, rsp_zero, rsp_carry    captured result and flags
//   busy                             sequencer is not idle
module alu_op_sequencer #(
  parameter int unsigned DATA_W        = 8,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_mode,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  output logic [DATA_W-1:0] alu_in_a,
  output logic [DATA_W-1:0] alu_in_b,
  output logic [3:0]        alu_mode,
  output logic              alu_ee,
  output logic              alu_eo,
  input  logic [DATA_W-1:0] alu_bus,
  input  logic              alu_carry,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_zero,
  output logic              rsp_carry,
  output logic              busy
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    EXEC = 3'd2,
    READ = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [CNT_W-1:0]  settle_cnt;
  logic              accept;

  // req_ready must react to rsp_ready in the same cycle for back-to-back issue
  assign req_ready = (state == IDLE) || ((state == DONE) && rsp_ready);
  assign accept    = req_ready && req_valid;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (req_valid) next_state = LOAD;
      LOAD: next_state = (SETTLE_CYCLES == 0) ? READ : EXEC;
      EXEC: if (settle_cnt <= CNT_W'(1)) next_state = READ;
      READ: next_state = DONE;
      DONE: if (rsp_ready) next_state = req_valid ? LOAD : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Strobes registered from next_state so they align with the state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_ee    <= 1'b0;
      alu_eo    <= 1'b0;
      rsp_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      alu_ee    <= (next_state == LOAD) || (next_state == EXEC) || (next_state == READ);
      alu_eo    <= (next_state == READ);
      rsp_valid <= (next_state == DONE);
      busy      <= (next_state != IDLE);
    end
  end

  // Settle down-counter: loaded in LOAD, counts the EXEC cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_cnt <= '0;
    end else if (state == LOAD) begin
      settle_cnt <= CNT_W'(SETTLE_CYCLES);
    end else if ((state == EXEC) && (settle_cnt != '0)) begin
      settle_cnt <= settle_cnt - CNT_W'(1);
    end
  end

  // Operand/mode capture; held stable until the next accepted request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_in_a <= '0;
      alu_in_b <= '0;
      alu_mode <= '0;
    end else if (accept) begin
      alu_in_a <= req_a;
      alu_in_b <= req_b;
      alu_mode <= req_mode;
    end
  end

  // Result capture; zero comes from the captured value, not the ALU flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_data  <= '0;
      rsp_zero  <= 1'b0;
      rsp_carry <= 1'b0;
    end else if (state == READ) begin
      rsp_data  <= alu_bus;
      rsp_zero  <= (alu_bus == '0);
      rsp_carry <= alu_carry;
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: three instances with SETTLE_CYCLES = 1, 0, 3,
// each paired with a small behavioural ALU that updates its result on every
// clock with ee high and drives the bus only while eo is high.
module tb_alu_op_sequencer;

  localparam int NDUT = 3;

  logic clk;
  logic rst_n;

  logic       req_valid [NDUT];
  logic       req_ready [NDUT];
  logic [3:0] req_mode  [NDUT];
  logic [7:0] req_a     [NDUT];
  logic [7:0] req_b     [NDUT];
  logic [7:0] alu_in_a  [NDUT];
  logic [7:0] alu_in_b  [NDUT];
  logic [3:0] alu_mode  [NDUT];
  logic       alu_ee    [NDUT];
  logic       alu_eo    [NDUT];
  logic [7:0] alu_bus   [NDUT];
  logic       alu_carry [NDUT];
  logic       rsp_valid [NDUT];
  logic       rsp_ready [NDUT];
  logic [7:0] rsp_data  [NDUT];
  logic       rsp_zero  [NDUT];
  logic       rsp_carry [NDUT];
  logic       busy      [NDUT];

  int checks = 0;
  int errors = 0;

  // Reference ALU: {carry, result}
  function automatic logic [8:0] ref_alu(input logic [3:0] m, input logic [7:0] a, input logic [7:0] b);
    case (m)
      4'd0:    return 9'(a) + 9'(b);
      4'd1:    return {1'(a < b), 8'(a - b)};
      4'd2:    return {1'b0, a & b};
      4'd3:    return {1'b0, a | b};
      4'd4:    return {1'b0, a ^ b};
      default: return {1'b0, a};
    endcase
  endfunction

  function automatic int settle_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 0 : 3);
  endfunction

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    logic [7:0] res;
    logic       cy;

    alu_op_sequencer #(.DATA_W(8), .SETTLE_CYCLES((g == 0) ? 1 : ((g == 1) ? 0 : 3))) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_mode  (req_mode[g]),
      .req_a     (req_a[g]),
      .req_b     (req_b[g]),
      .alu_in_a  (alu_in_a[g]),
      .alu_in_b  (alu_in_b[g]),
      .alu_mode  (alu_mode[g]),
      .alu_ee    (alu_ee[g]),
      .alu_eo    (alu_eo[g]),
      .alu_bus   (alu_bus[g]),
      .alu_carry (alu_carry[g]),
      .rsp_valid (rsp_valid[g]),
      .rsp_ready (rsp_ready[g]),
      .rsp_data  (rsp_data[g]),
      .rsp_zero  (rsp_zero[g]),
      .rsp_carry (rsp_carry[g]),
      .busy      (busy[g])
    );

    always @(posedge clk) begin
      if (alu_ee[g]) {cy, res} <= ref_alu(alu_mode[g], alu_in_a[g], alu_in_b[g]);
    end

    // Idle bus carries a filler pattern so a mistimed capture is visible
    assign alu_bus[g]   = alu_eo[g] ? res : 8'h5A;
    assign alu_carry[g] = cy;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete operation on instance k; checks latency, strobes, stability
  // under back-pressure, and single consumption. Returns the captured result.
  task automatic do_op(input int k, input logic [3:0] m, input logic [7:0] a, input logic [7:0] b,
                       input int hold, input bit junk,
                       output logic [7:0] d, output logic z, output logic c);
    int guard, lat, ee_n, eo_n;
    bit unstable;
    int s;
    s = settle_of(k);
    req_mode[k] = m; req_a[k] = a; req_b[k] = b; req_valid[k] = 1'b1;
    guard = 0;
    while (!req_ready[k] && guard < 20) begin step(); guard++; end
    check("accept_timeout", 32'(guard < 20), 32'd1);
    step();
    req_valid[k] = 1'b0;
    req_a[k] = $urandom; req_b[k] = $urandom; req_mode[k] = 4'($urandom);
    lat = 0; ee_n = 0; eo_n = 0; unstable = 1'b0;
    while (!rsp_valid[k] && lat < 40) begin
      ee_n += int'(alu_ee[k]);
      eo_n += int'(alu_eo[k]);
      if (alu_in_a[k] !== a || alu_in_b[k] !== b || alu_mode[k] !== m || req_ready[k] !== 1'b0 ||
          busy[k] !== 1'b1)
        unstable = 1'b1;
      step();
      lat++;
    end
    check("latency", 32'(lat), 32'(2 + s));
    check("ee_cycles_before_read", 32'(ee_n - 1), 32'(1 + s));
    check("eo_cycles", 32'(eo_n), 32'd1);
    check("operands_stable", 32'(unstable), 32'd0);
    check("ee_low_in_done", 32'(alu_ee[k]), 32'd0);
    d = rsp_data[k]; z = rsp_zero[k]; c = rsp_carry[k];
    unstable = 1'b0;
    for (int i = 0; i < hold; i++) begin
      if (junk) begin
        req_valid[k] = 1'b1; req_a[k] = ~a; req_b[k] = ~b; req_mode[k] = ~m;
      end
      #1;
      if (req_ready[k] !== 1'b0 || rsp_valid[k] !== 1'b1 || rsp_data[k] !== d ||
          rsp_zero[k] !== z || rsp_carry[k] !== c || alu_eo[k] !== 1'b0)
        unstable = 1'b1;
      step();
    end
    check("backpressure_hold", 32'(unstable), 32'd0);
    req_valid[k] = 1'b0;
    rsp_ready[k] = 1'b1;
    #1;
    check("req_ready_on_consume", 32'(req_ready[k]), 32'd1);
    step();
    rsp_ready[k] = 1'b0;
    check("consumed_once", 32'(rsp_valid[k]), 32'd0);
    check("idle_after_consume", 32'(busy[k]), 32'd0);
    if (hold > 0) check("junk_ignored", 32'(alu_in_a[k]), 32'(a));
  endtask

  typedef struct {
    logic [3:0] mode;
    logic [7:0] a;
    logic [7:0] b;
    int         hold;
    logic [7:0] exp_d;
    logic       exp_z;
    logic       exp_c;
  } vec_t;

  vec_t vecs [7];

  initial begin
    logic [7:0] d;
    logic       z, c;
    logic [8:0] r;
    int first_c, second_c, nvalid;
    logic [7:0] first_d, second_d;
    logic first_z, second_z;

    vecs[0] = '{4'd0,  8'h0F, 8'h01, 0, 8'h10, 1'b0, 1'b0};
    vecs[1] = '{4'd0,  8'hFF, 8'h01, 0, 8'h00, 1'b1, 1'b1};
    vecs[2] = '{4'd4,  8'hAA, 8'hFF, 0, 8'h55, 1'b0, 1'b0};
    vecs[3] = '{4'd2,  8'hF0, 8'h0F, 5, 8'h00, 1'b1, 1'b0};
    vecs[4] = '{4'd1,  8'h05, 8'h07, 2, 8'hFE, 1'b0, 1'b1};
    vecs[5] = '{4'd3,  8'h80, 8'h01, 0, 8'h81, 1'b0, 1'b0};
    vecs[6] = '{4'd15, 8'h3C, 8'h99, 1, 8'h3C, 1'b0, 1'b0};

    rst_n = 1'b0;
    for (int k = 0; k < NDUT; k++) begin
      req_valid[k] = 1'b0; req_mode[k] = '0; req_a[k] = '0; req_b[k] = '0; rsp_ready[k] = 1'b0;
    end
    step(); step();
    for (int k = 0; k < NDUT; k++) begin
      check("reset_req_ready", 32'(req_ready[k]), 32'd1);
      check("reset_outputs", {alu_in_a[k], alu_in_b[k], alu_mode[k], alu_ee[k], alu_eo[k],
                              rsp_valid[k], busy[k]}, 32'd0);
      check("reset_rsp", {rsp_data[k], rsp_zero[k], rsp_carry[k]}, 32'd0);
    end
    rst_n = 1'b1;
    step();

    // Directed vectors on the default instance
    foreach (vecs[i]) begin
      do_op(0, vecs[i].mode, vecs[i].a, vecs[i].b, vecs[i].hold, (vecs[i].hold > 0), d, z, c);
      check($sformatf("vec%0d_data", i), 32'(d), 32'(vecs[i].exp_d));
      check($sformatf("vec%0d_zero", i), 32'(z), 32'(vecs[i].exp_z));
      check($sformatf("vec%0d_carry", i), 32'(c), 32'(vecs[i].exp_c));
    end

    // Other settle depths
    for (int k = 1; k < NDUT; k++) begin
      do_op(k, vecs[1].mode, vecs[1].a, vecs[1].b, 1, 1'b1, d, z, c);
      check("settle_data", 32'(d), 32'(vecs[1].exp_d));
      check("settle_flags", {z, c}, {vecs[1].exp_z, vecs[1].exp_c});
    end

    // Back-to-back: XOR then AND with rsp_ready held high
    rsp_ready[0] = 1'b1;
    req_mode[0] = 4'd4; req_a[0] = 8'hAA; req_b[0] = 8'hFF; req_valid[0] = 1'b1;
    check("b2b_idle_ready", 32'(req_ready[0]), 32'd1);
    step();
    req_mode[0] = 4'd2; req_a[0] = 8'hF0; req_b[0] = 8'h0F;
    first_c = -1; second_c = -1; nvalid = 0;
    first_d = '0; second_d = '0; first_z = 1'b0; second_z = 1'b0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (cyc == 4) req_valid[0] = 1'b0;
      if (rsp_valid[0]) begin
        nvalid++;
        if (first_c < 0) begin
          first_c = cyc; first_d = rsp_data[0]; first_z = rsp_zero[0];
          check("b2b_done_ready", 32'(req_ready[0]), 32'd1);
        end else begin
          second_c = cyc; second_d = rsp_data[0]; second_z = rsp_zero[0];
        end
      end
      step();
    end
    rsp_ready[0] = 1'b0;
    check("b2b_first_cycle", 32'(first_c), 32'd3);
    check("b2b_second_cycle", 32'(second_c), 32'd7);
    check("b2b_count", 32'(nvalid), 32'd2);
    check("b2b_first", {first_d, first_z}, {8'h55, 1'b0});
    check("b2b_second", {second_d, second_z}, {8'h00, 1'b1});

    // Randomised operations against the reference ALU
    for (int k = 0; k < NDUT; k++) begin
      for (int n = 0; n < 25; n++) begin
        logic [3:0] m;
        logic [7:0] a, b;
        m = 4'($urandom_range(0, 15));
        a = 8'($urandom); b = 8'($urandom);
        if (n % 5 == 0) b = 8'(-a);
        r = ref_alu(m, a, b);
        do_op(k, m, a, b, int'($urandom_range(0, 3)), 1'($urandom), d, z, c);
        check("rand_data", 32'(d), 32'(r[7:0]));
        check("rand_zero", 32'(z), 32'(r[7:0] == 8'h00));
        check("rand_carry", 32'(c), 32'(r[8]));
      end
    end

    // Reset asserted in READ: outputs clear without a clock edge
    req_mode[0] = 4'd0; req_a[0] = 8'h12; req_b[0] = 8'h34; req_valid[0] = 1'b1;
    step();
    req_valid[0] = 1'b0;
    step(); step();
    check("pre_reset_eo", {alu_eo[0], alu_ee[0]}, 32'd3);
    #1 rst_n = 1'b0;
    #1;
    check("async_reset_strobes", {alu_ee[0], alu_eo[0], rsp_valid[0], busy[0]}, 32'd0);
    check("async_reset_data", {alu_in_a[0], alu_in_b[0], alu_mode[0], rsp_data[0]}, 32'd0);
    check("async_reset_flags", {rsp_zero[0], rsp_carry[0]}, 32'd0);
    #5 rst_n = 1'b1;
    step();
    check("post_reset_ready", {req_ready[0], busy[0]}, 32'd2);
    nvalid = 0;
    for (int i = 0; i < 6; i++) begin
      nvalid += int'(rsp_valid[0]);
      step();
    end
    check("aborted_no_response", 32'(nvalid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
